// File: rtl/ierl78prtyerrv1.sv
// ierl78prtyerrv1 - RL78 IECUBE RAM parity-error capture block.
// Records the first failing address, a sticky error flag, an overflow flag
// and a saturating error count, and returns them on the ICE data OR-bus.
module ierl78prtyerrv1 #(
    parameter int         ADRW   = 20,
    parameter int         CNTW   = 8,
    parameter logic [7:0] STSADR = 8'h40,
    parameter logic [7:0] ADRADR = 8'h41
) (
    input  logic            BASECK,
    input  logic            RESB,
    input  logic            PRTYERR,
    input  logic [ADRW-1:0] PERRADR,
    input  logic [7:0]      ICEADR,
    input  logic            ICERD,
    input  logic            ICEWR,
    input  logic [31:0]     ICEDIP,
    output logic ICEDOPB31, output logic ICEDOPB30, output logic ICEDOPB29, output logic ICEDOPB28,
    output logic ICEDOPB27, output logic ICEDOPB26, output logic ICEDOPB25, output logic ICEDOPB24,
    output logic ICEDOPB23, output logic ICEDOPB22, output logic ICEDOPB21, output logic ICEDOPB20,
    output logic ICEDOPB19, output logic ICEDOPB18, output logic ICEDOPB17, output logic ICEDOPB16,
    output logic ICEDOPB15, output logic ICEDOPB14, output logic ICEDOPB13, output logic ICEDOPB12,
    output logic ICEDOPB11, output logic ICEDOPB10, output logic ICEDOPB9,  output logic ICEDOPB8,
    output logic ICEDOPB7,  output logic ICEDOPB6,  output logic ICEDOPB5,  output logic ICEDOPB4,
    output logic ICEDOPB3,  output logic ICEDOPB2,  output logic ICEDOPB1,  output logic ICEDOPB0,
    output logic            ICEPERRINT
);

    typedef enum logic [1:0] {CLEAN, CAPTURED, OVERFLOW} cap_e;
    typedef enum logic       {IDLE, DRIVE} rd_e;

    cap_e            cap_q;
    rd_e             rd_q;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [ADRW-1:0] adr_q;
    logic            inten_q;
    logic [31:0]     dout_q;
    logic [31:0]     sts_w, adr_w;
    logic            sts_wr, clr, rd_hit;
    logic            unused_dip;

    // Only ICEDIP[0] (clear) and ICEDIP[16] (INTEN) carry meaning.
    assign unused_dip = ^{ICEDIP[31:17], ICEDIP[15:1]};

    assign sts_wr = ICEWR && (ICEADR == STSADR);
    assign clr    = sts_wr && ICEDIP[0];
    assign rd_hit = ICERD && ((ICEADR == STSADR) || (ICEADR == ADRADR));
    assign cnt_d  = (cnt_q == {CNTW{1'b1}}) ? cnt_q : cnt_q + CNTW'(1);

    // Assemble the two readable register images from current state.
    always_comb begin
        sts_w             = '0;
        sts_w[0]          = (cap_q != CLEAN);
        sts_w[1]          = (cap_q == OVERFLOW);
        sts_w[8 +: CNTW]  = cnt_q;
        sts_w[16]         = inten_q;
        adr_w             = '0;
        adr_w[ADRW-1:0]   = adr_q;
    end

    // Capture FSM: a new error outranks a simultaneous clear, so a clear
    // plus error restarts the capture with the new address.
    always_ff @(posedge BASECK or negedge RESB) begin
        if (!RESB) begin
            cap_q   <= CLEAN;
            cnt_q   <= '0;
            adr_q   <= '0;
            inten_q <= 1'b0;
        end else begin
            if (sts_wr) inten_q <= ICEDIP[16];
            if (PRTYERR) begin
                if (clr || cap_q == CLEAN) begin
                    cap_q <= CAPTURED;
                    cnt_q <= CNTW'(1);
                    adr_q <= PERRADR;
                end else begin
                    cap_q <= OVERFLOW;
                    cnt_q <= cnt_d;
                end
            end else if (clr) begin
                cap_q <= CLEAN;
                cnt_q <= '0;
                adr_q <= '0;
            end
        end
    end

    // Read FSM: one driven cycle per matching ICERD, zero otherwise so the
    // OR-bus merge with the other source stays clean.
    always_ff @(posedge BASECK or negedge RESB) begin
        if (!RESB) begin
            rd_q   <= IDLE;
            dout_q <= '0;
        end else if (rd_hit) begin
            rd_q   <= DRIVE;
            dout_q <= (ICEADR == STSADR) ? sts_w : adr_w;
        end else begin
            rd_q   <= IDLE;
            dout_q <= '0;
        end
    end

    assign ICEPERRINT = (cap_q != CLEAN) && inten_q;

    assign ICEDOPB31 = dout_q[31]; assign ICEDOPB30 = dout_q[30];
    assign ICEDOPB29 = dout_q[29]; assign ICEDOPB28 = dout_q[28];
    assign ICEDOPB27 = dout_q[27]; assign ICEDOPB26 = dout_q[26];
    assign ICEDOPB25 = dout_q[25]; assign ICEDOPB24 = dout_q[24];
    assign ICEDOPB23 = dout_q[23]; assign ICEDOPB22 = dout_q[22];
    assign ICEDOPB21 = dout_q[21]; assign ICEDOPB20 = dout_q[20];
    assign ICEDOPB19 = dout_q[19]; assign ICEDOPB18 = dout_q[18];
    assign ICEDOPB17 = dout_q[17]; assign ICEDOPB16 = dout_q[16];
    assign ICEDOPB15 = dout_q[15]; assign ICEDOPB14 = dout_q[14];
    assign ICEDOPB13 = dout_q[13]; assign ICEDOPB12 = dout_q[12];
    assign ICEDOPB11 = dout_q[11]; assign ICEDOPB10 = dout_q[10];
    assign ICEDOPB9  = dout_q[9];  assign ICEDOPB8  = dout_q[8];
    assign ICEDOPB7  = dout_q[7];  assign ICEDOPB6  = dout_q[6];
    assign ICEDOPB5  = dout_q[5];  assign ICEDOPB4  = dout_q[4];
    assign ICEDOPB3  = dout_q[3];  assign ICEDOPB2  = dout_q[2];
    assign ICEDOPB1  = dout_q[1];  assign ICEDOPB0  = dout_q[0];

endmodule

// File: doc/ierl78prtyerrv1.md
# ierl78prtyerrv1

RL78 IECUBE parity-error capture block. It latches RAM parity errors reported by the core-side RAM checker: a sticky error flag, an overflow flag, an error count, and the address of the first failing access. It exposes these as two ICE-readable registers. Read data is driven onto the ICEDOPB half of the ICE data OR-bus, and the OR-bus merges it with the icescon read data (ICEDOPA) into ICEDOP. Between reads the block drives all-zero onto ICEDOPB, as the OR-bus requires.

## Interface
Parameters:
- ADRW, 20: width of the captured failing address.
- CNTW, 8: width of the saturating error counter.
- STSADR, 8'h40: ICE register address of PERRSTS.
- ADRADR, 8'h41: ICE register address of PERRADR.

Ports:
- BASECK  input  1  ICE base clock; all state changes on its rising edge.
- RESB  input  1  asynchronous active-low reset.
- PRTYERR  input  1  one-cycle parity-error strobe from the RAM checker.
- PERRADR  input  ADRW  address of the access flagged by PRTYERR; valid only while PRTYERR=1.
- ICEADR  input  8  ICE register address.
- ICERD  input  1  one-cycle read strobe.
- ICEWR  input  1  one-cycle write strobe.
- ICEDIP  input  32  ICE write data.
- ICEDOPB31..ICEDOPB0  output  1 each  read data onto the OR-bus; zero when not driving.
- ICEPERRINT  output  1  error interrupt to the ICE break controller.

## Operation
PERRSTS layout:
- bit0 ERR: sticky.
- bit1 OVF: set by a second error while ERR=1.
- bits[8+CNTW-1:8] CNT: saturating count, holds at 2^CNTW-1.
- bit16 INTEN.
- All other bits read 0.

PERRADR layout: bits[ADRW-1:0] hold the address of the first error since the last clear. Upper bits read 0.

Capture FSM, states CLEAN / CAPTURED / OVERFLOW:
- CLEAN + PRTYERR: go to CAPTURED. ERR=1, CNT=1, PERRADR latched.
- CAPTURED + PRTYERR: go to OVERFLOW. OVF=1, CNT+1. The address is not overwritten.
- OVERFLOW + PRTYERR: CNT+1, saturating. No other change.
- Clear (write to STSADR with ICEDIP[0]=1) from any state: go to CLEAN. ERR, OVF, CNT and PERRADR are zeroed.
- Clear and PRTYERR in the same cycle: the error wins over the old state. Result is CAPTURED, CNT=1, new address latched, OVF=0.

Writes:
- A write to STSADR loads INTEN from ICEDIP[16] regardless of ICEDIP[0].
- Writes to ADRADR or to any other address are ignored.

Reads:
- Read FSM has two states, IDLE and DRIVE.
- ICERD with ICEADR equal to STSADR or ADRADR: IDLE → DRIVE. The read-data register captures the selected register value from before the current edge's updates.
- DRIVE always returns to IDLE the next cycle. The data register is zeroed on return unless a new matching ICERD re-arms it.
- ICERD to any other address: the block stays in IDLE and ICEDOPB stays 0.
- ICERD and ICEWR in the same cycle: both are performed. The read returns the pre-write value.

ICEPERRINT = ERR & INTEN, taken from registered state.

## Timing
- Reset (RESB=0, asynchronous, any time including mid-read):
  - ICEDOPB = 0 immediately; ICEPERRINT = 0.
  - ERR = OVF = 0, CNT = 0, PERRADR = 0, INTEN = 0.
  - Both FSMs go to their idle/CLEAN state.
- PRTYERR sampled at edge n: flags, CNT and address are visible in registers after edge n; ICEPERRINT rises after edge n.
- Read latency: ICERD at edge n → ICEDOPB valid for exactly the cycle after edge n, then 0 after edge n+1.
- Back-to-back reads on consecutive cycles: ICEDOPB stays driven, one value per cycle.
- Error and read of PERRSTS on the same edge: the read returns the old value. The next read shows the update.
- CNT at 2^CNTW-1: further errors leave CNT unchanged. OVF stays 1.

## Test plan
- Reset, then read PERRSTS and PERRADR → ICEDOPB = 32'h0 both times, and 0 in every non-read cycle.
- Write PERRSTS = 32'h0001_0000; pulse PRTYERR with PERRADR = 20'hF_E123 → ICEPERRINT = 1 the next cycle. PERRSTS reads 32'h0001_0101; PERRADR reads 32'h000F_E123.
- Second PRTYERR with address 20'h0_0010 → PERRSTS reads 32'h0001_0203; PERRADR still reads 32'h000F_E123.
- 300 PRTYERR pulses from CLEAN → CNT = 8'hFF, OVF = 1, ERR = 1.
- Write PERRSTS with ICEDIP = 32'h0001_0001 in the same cycle as PRTYERR with address 20'h1_2345 → PERRSTS = 32'h0001_0101, PERRADR = 32'h0001_2345.
- Assert RESB low while ICEDOPB is driving 32'h0001_0101 → ICEDOPB = 0 with no clock edge needed. All registers read 0 after release.
